// File: rtl/shift_pkg.sv
// ----------------------------------------------------------------------------
// shift_pkg
// Constants and types shared by the left and right shifters.
//   DEFAULT_DATA_W : default operand/result width (power of two, >= 2)
//   cnt_w()        : shift-count width for a given data width
//   state_t        : FSM state encoding used by the sequential shifter
// Ports: none (package).
// ----------------------------------------------------------------------------
package shift_pkg;

    localparam int DEFAULT_DATA_W = 32;

    // A count of 0..DATA_W-1 needs log2(DATA_W) bits.
    function automatic int cnt_w(input int data_w);
        return $clog2(data_w);
    endfunction

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_left_seq_if.sv
// ----------------------------------------------------------------------------
// shift_left_seq_if
// Bundle of the operand and result handshakes of shift_left_seq.
//
// Handshake rule (both channels): a transfer happens on a rising clock edge
// where valid and ready are both high. The sender holds its payload stable
// only as required by the receiver; shift_left_seq samples A/cnt/rot solely
// on the accept edge and holds B/ovf stable for as long as out_valid is high.
//
// Signals:
//   in_valid  (master->slave) operand and count present
//   in_ready  (slave->master) shifter can accept (IDLE only)
//   A         (master->slave) operand, DATA_W bits
//   cnt       (master->slave) shift amount, CNT_W bits
//   rot       (master->slave) rotate request, only with SHL_ROTATE_EN
//   out_valid (slave->master) result present (DONE only)
//   out_ready (master->slave) consumer takes result
//   B         (slave->master) shifted result
//   ovf       (slave->master) a 1 bit left the MSB during the operation
// Configuration macro: SHL_ROTATE_EN adds the rot signal.
// ----------------------------------------------------------------------------
interface shift_left_seq_if
    import shift_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
);
    localparam int CNT_W = cnt_w(DATA_W);

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] A;
    logic [CNT_W-1:0]  cnt;
`ifdef SHL_ROTATE_EN
    logic              rot;
`endif
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] B;
    logic              ovf;

    modport master (
        output in_valid,
        output A,
        output cnt,
`ifdef SHL_ROTATE_EN
        output rot,
`endif
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  B,
        input  ovf
    );

    modport slave (
        input  in_valid,
        input  A,
        input  cnt,
`ifdef SHL_ROTATE_EN
        input  rot,
`endif
        input  out_ready,
        output in_ready,
        output out_valid,
        output B,
        output ovf
    );

endinterface

// File: rtl/shift_left_seq.sv
// ----------------------------------------------------------------------------
// shift_left_seq
// Sequential logical left shifter: accepts an operand and a count, shifts one
// bit per clock, then presents the result and an overflow flag that is set
// when any 1 bit was shifted out past the MSB.
//
// Ports:
//   clk      rising-edge clock
//   rst_n    asynchronous active-low reset
//   bus      shift_left_seq_if.slave (operand and result handshakes)
//   o_state  current FSM state, for observation
// Configuration macro: SHL_ROTATE_EN enables rotate-left via bus.rot; in that
// mode the MSB wraps into the LSB and ovf stays 0 for the operation.
// ----------------------------------------------------------------------------
module shift_left_seq
    import shift_pkg::*;
#(
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic             clk,
    input  logic             rst_n,
    shift_left_seq_if.slave  bus,
    output state_t           o_state
);
    localparam int CNT_W = cnt_w(DATA_W);

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] w_data_nxt;
    logic [CNT_W-1:0]  r_rem;
    logic [CNT_W-1:0]  w_rem_nxt;
    logic              r_ovf;
    logic              w_ovf_nxt;
    logic [DATA_W-1:0] r_b;
    logic              r_ovf_out;
    logic              w_in_ready;
    logic              w_out_valid;
    logic              w_fill;
    logic              w_rotating;
`ifdef SHL_ROTATE_EN
    logic              r_rot;
    logic              w_rot_nxt;

    assign w_rotating = r_rot;
`else
    assign w_rotating = 1'b0;
`endif

    // Rotate feeds the outgoing MSB back in at the LSB; logical feeds zero.
    assign w_fill = w_rotating & r_data[DATA_W-1];

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state, datapath next values and handshake outputs.
    always_comb begin
        w_state_nxt = r_state;
        w_data_nxt  = r_data;
        w_rem_nxt   = r_rem;
        w_ovf_nxt   = r_ovf;
`ifdef SHL_ROTATE_EN
        w_rot_nxt   = r_rot;
`endif
        w_in_ready  = 1'b0;
        w_out_valid = 1'b0;

        case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_data_nxt = bus.A;
                    w_rem_nxt  = bus.cnt;
                    w_ovf_nxt  = 1'b0;
`ifdef SHL_ROTATE_EN
                    w_rot_nxt  = bus.rot;
`endif
                    w_state_nxt = (bus.cnt == '0) ? DONE : SHIFT;
                end
            end
            SHIFT: begin
                w_data_nxt = {r_data[DATA_W-2:0], w_fill};
                w_ovf_nxt  = r_ovf | (r_data[DATA_W-1] & ~w_rotating);
                w_rem_nxt  = r_rem - CNT_W'(1);
                // SHIFT is only entered with r_rem >= 1, so this never wraps.
                if (r_rem == CNT_W'(1)) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                w_out_valid = 1'b1;
                if (bus.out_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Working registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_data <= '0;
            r_rem  <= '0;
            r_ovf  <= 1'b0;
`ifdef SHL_ROTATE_EN
            r_rot  <= 1'b0;
`endif
        end else begin
            r_data <= w_data_nxt;
            r_rem  <= w_rem_nxt;
            r_ovf  <= w_ovf_nxt;
`ifdef SHL_ROTATE_EN
            r_rot  <= w_rot_nxt;
`endif
        end
    end

    // Result registers are loaded only on entry to DONE, so B/ovf keep the
    // last result after the handshake instead of following the next operand.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_b       <= '0;
            r_ovf_out <= 1'b0;
        end else if ((w_state_nxt == DONE) && (r_state != DONE)) begin
            r_b       <= w_data_nxt;
            r_ovf_out <= w_ovf_nxt;
        end
    end

    // The state register sits in IDLE during reset; gate in_ready so the
    // block does not advertise readiness until reset is released.
    assign bus.in_ready  = w_in_ready & rst_n;
    assign bus.out_valid = w_out_valid;
    assign bus.B         = r_b;
    assign bus.ovf       = r_ovf_out;
    assign o_state       = r_state;

endmodule

// File: tb/tb_shift_left_seq.sv
// ----------------------------------------------------------------------------
// tb_shift_left_seq
// Bench for shift_left_seq: directed cases, randomized operations scored
// against a wide-arithmetic reference model, backpressure and reset abort.
// Configuration macro: SHL_ROTATE_EN adds rotate stimulus.
// ----------------------------------------------------------------------------
module tb_shift_left_seq;
    import shift_pkg::*;

    logic   clk = 1'b0;
    logic   rst_n;
    state_t dbg_state;

    always #5 clk = ~clk;

    shift_left_seq_if bus ();

    shift_left_seq dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .bus     (bus),
        .o_state (dbg_state)
    );

    int          checks   = 0;
    int          failures = 0;
    logic [32:0] exp_q[$];
    logic [32:0] last_exp;

    // Reference: shift into a 64-bit space. Bits landing above bit 31 are the
    // ones that left the MSB; rotation ORs them back into the low word.
    function automatic logic [32:0] model(input logic [31:0] a, input int c, input bit r);
        logic [63:0] wide;
        wide = {32'b0, a} << c;
        if (r) return {1'b0, wide[31:0] | wide[63:32]};
        return {|wide[63:32], wide[31:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drive_rot(input bit r);
`ifdef SHL_ROTATE_EN
        bus.rot = r;
`else
        if (r) $display("rotate not built; running logical");
`endif
    endtask

    // Called at a negedge while IDLE; returns at the negedge after accept.
    task automatic start_op(input logic [31:0] a, input int c, input bit r);
        bit eff_r;
`ifdef SHL_ROTATE_EN
        eff_r = r;
`else
        eff_r = 1'b0;
`endif
        check("in_ready_idle", 32'(bus.in_ready), 32'd1);
        exp_q.push_back(model(a, c, eff_r));
        bus.in_valid = 1'b1;
        bus.A        = a;
        bus.cnt      = 5'(c);
        drive_rot(eff_r);
        @(posedge clk);
        @(negedge clk);
        // Scramble inputs: only the accept edge may matter.
        bus.in_valid = 1'b0;
        bus.A        = $urandom;
        bus.cnt      = 5'($urandom_range(0, 31));
        drive_rot(1'b0);
    endtask

    // Counts edges from accept until out_valid, then scores the result.
    task automatic finish_op(input int c);
        int k;
        k = 0;
        while (!bus.out_valid && k < 40) begin
            @(posedge clk);
            @(negedge clk);
            k++;
        end
        check("latency", 32'(k), 32'(c));
        if (exp_q.size() == 0) begin
            check("scoreboard_nonempty", 32'd0, 32'd1);
            last_exp = '0;
        end else begin
            last_exp = exp_q.pop_front();
        end
        check("result_B", bus.B, last_exp[31:0]);
        check("result_ovf", 32'(bus.ovf), 32'(last_exp[32]));
    endtask

    task automatic do_op(input logic [31:0] a, input int c, input bit r);
        start_op(a, c, r);
        finish_op(c);
        @(posedge clk);
        @(negedge clk);
        check("back_to_idle", 32'(bus.out_valid), 32'd0);
    endtask

    initial begin
        logic [31:0] a;
        int          c;
        bit          r;

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.A         = '0;
        bus.cnt       = '0;
        bus.out_ready = 1'b1;
        drive_rot(1'b0);
        last_exp      = '0;

        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(bus.in_ready), 32'd0);
        check("rst_out_valid", 32'(bus.out_valid), 32'd0);
        check("rst_B", bus.B, 32'd0);
        check("rst_ovf", 32'(bus.ovf), 32'd0);
        check("rst_state", 32'(dbg_state), 32'(IDLE));
        rst_n = 1'b1;
        @(negedge clk);

        // Directed cases.
        do_op(32'h0000_0001, 4, 1'b0);
        check("dir_shl4", last_exp[31:0], 32'h0000_0010);
        do_op(32'hDEAD_BEEF, 0, 1'b0);
        do_op(32'h8000_0003, 31, 1'b0);
        check("dir_max_cnt_ovf", 32'(last_exp[32]), 32'd1);

        // Randomized operations.
        for (int i = 0; i < 16; i++) begin
            a = $urandom;
            if (i % 4 == 0) a = a >> $urandom_range(0, 31);
            c = $urandom_range(0, 31);
            r = 1'($urandom_range(0, 1));
            do_op(a, c, r);
        end

        // Backpressure: hold DONE, keep offering a new operand.
        bus.out_ready = 1'b0;
        start_op(32'h1234_5678, 3, 1'b0);
        finish_op(3);
        bus.in_valid = 1'b1;
        bus.A        = 32'h0000_00F0;
        bus.cnt      = 5'd2;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            @(negedge clk);
            check("bp_in_ready", 32'(bus.in_ready), 32'd0);
            check("bp_out_valid", 32'(bus.out_valid), 32'd1);
            check("bp_B_hold", bus.B, last_exp[31:0]);
        end
        bus.out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("bp_release_out_valid", 32'(bus.out_valid), 32'd0);
        start_op(32'h0000_00F0, 2, 1'b0);
        finish_op(2);
        check("bp_next_B", bus.B, 32'h0000_03C0);
        @(posedge clk);
        @(negedge clk);

        // Reset in the middle of a long shift.
        start_op(32'hFFFF_FFFF, 20, 1'b0);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst_B", bus.B, 32'd0);
        check("midrst_ovf", 32'(bus.ovf), 32'd0);
        check("midrst_in_ready", 32'(bus.in_ready), 32'd0);
        void'(exp_q.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        do_op(32'h0000_0001, 1, 1'b0);
        check("post_rst_B", last_exp[31:0], 32'h0000_0002);

`ifdef SHL_ROTATE_EN
        do_op(32'h8000_0001, 1, 1'b1);
        check("rot_B", last_exp[31:0], 32'h0000_0003);
        check("rot_ovf", 32'(last_exp[32]), 32'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
